pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit.sv | 111 +++++++++++
 tb/tb_pc_unit.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program counter unit with an 8-deep internal return stack.
// On every rising edge with PCw high the PC takes exactly one of these
// actions, highest priority first: flag a call/return conflict, return,
// call, conditional jump, or plain increment. Anomalies (conflict, stack
// overflow, stack underflow) advance the PC by one and set a sticky error
// flag that only reset clears. All PC arithmetic wraps modulo 256.
// The return request port is named "ret" because "return" is a reserved
// word in SystemVerilog.
module pc_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic       PCw,
  input  logic       jump,
  input  logic [1:0] j_mode,
  input  logic       call,
  input  logic       ret,
  input  logic [7:0] target,
  input  logic       zero,
  input  logic       carry,
  output logic [7:0] pc,
  output logic [3:0] stack_depth,
  output logic       stack_full,
  output logic       stack_empty,
  output logic       stack_err
);

  localparam logic [3:0] DEPTH_MAX = 4'd8;

  logic [7:0] stack_mem [8];

  logic [7:0] pc_inc;
  logic [7:0] pc_next;
  logic [3:0] depth_next;
  logic       err_next;
  logic       push;
  logic       jump_taken;
  logic [3:0] top_pos;
  logic [2:0] top_idx;
  logic [2:0] push_idx;

  assign pc_inc   = pc + 8'd1;
  assign top_pos  = stack_depth - 4'd1;
  assign top_idx  = top_pos[2:0];
  assign push_idx = stack_depth[2:0];

  // Status flags are pure decodes of the registered depth.
  assign stack_full  = (stack_depth == DEPTH_MAX);
  assign stack_empty = (stack_depth == 4'd0);

  // Jump condition decode on the sampled flags.
  always_comb begin
    jump_taken = 1'b0;
    case (j_mode)
      2'b00:   jump_taken = 1'b1;
      2'b01:   jump_taken = zero;
      2'b10:   jump_taken = carry;
      2'b11:   jump_taken = ~zero;
      default: jump_taken = 1'b0;
    endcase
  end

  // Next-state selection: conflict > return > call > jump > increment.
  always_comb begin
    pc_next    = pc_inc;
    depth_next = stack_depth;
    err_next   = stack_err;
    push       = 1'b0;
    if (call && ret) begin
      err_next = 1'b1;
    end else if (ret) begin
      if (!stack_empty) begin
        pc_next    = stack_mem[top_idx];
        depth_next = top_pos;
      end else begin
        err_next = 1'b1;
      end
    end else if (call) begin
      if (!stack_full) begin
        push       = 1'b1;
        pc_next    = target;
        depth_next = stack_depth + 4'd1;
      end else begin
        err_next = 1'b1;
      end
    end else if (jump && jump_taken) begin
      pc_next = target;
    end
  end

  // PC, depth and sticky error register; updates only when PCw is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= 8'h00;
      stack_depth <= 4'd0;
      stack_err   <= 1'b0;
    end else if (PCw) begin
      pc          <= pc_next;
      stack_depth <= depth_next;
      stack_err   <= err_next;
    end
  end

  // Stack storage: contents after reset are don't-care, so no reset here.
  // The return address pushed is pc+1, which wraps 8'hFF to 8'h00.
  always_ff @(posedge clk) begin
    if (PCw && push) begin
      stack_mem[push_idx] <= pc_inc;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: a reference model predicts {err, full, empty, depth, pc}
// for every driven cycle and queues it; each test pops and compares after
// the clock edge.
module tb_pc_unit;

  localparam int W = 15;

  logic       clk;
  logic       rst;
  logic       PCw;
  logic       jump;
  logic [1:0] j_mode;
  logic       call;
  logic       ret;
  logic [7:0] target;
  logic       zero;
  logic       carry;
  logic [7:0] pc;
  logic [3:0] stack_depth;
  logic       stack_full;
  logic       stack_empty;
  logic       stack_err;

  logic [W-1:0] exp_q[$];
  int checks;
  int failures;

  // reference model state
  logic [7:0] m_pc;
  logic [3:0] m_depth;
  logic       m_err;
  logic [7:0] m_stack [8];
  logic [7:0] ret_log[$];

  pc_unit dut (
    .clk(clk), .rst(rst), .PCw(PCw), .jump(jump), .j_mode(j_mode),
    .call(call), .ret(ret), .target(target), .zero(zero), .carry(carry),
    .pc(pc), .stack_depth(stack_depth), .stack_full(stack_full),
    .stack_empty(stack_empty), .stack_err(stack_err)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] observed();
    return {stack_err, stack_full, stack_empty, stack_depth, pc};
  endfunction

  // Drive one cycle at the falling edge, predict, queue, then wait past the
  // rising edge so the caller can compare.
  task automatic step(input logic pcw_i, input logic call_i, input logic ret_i,
                      input logic jump_i, input logic [1:0] jm_i,
                      input logic [7:0] tgt_i, input logic z_i, input logic c_i);
    logic [7:0] inc;
    logic taken;
    @(negedge clk);
    PCw = pcw_i; call = call_i; ret = ret_i; jump = jump_i;
    j_mode = jm_i; target = tgt_i; zero = z_i; carry = c_i;
    if (pcw_i) begin
      inc = m_pc + 8'd1;
      if (call_i && ret_i) begin
        m_pc = inc; m_err = 1'b1;
      end else if (ret_i) begin
        if (m_depth != 0) begin
          m_depth = m_depth - 4'd1;
          m_pc = m_stack[m_depth[2:0]];
        end else begin
          m_pc = inc; m_err = 1'b1;
        end
      end else if (call_i) begin
        if (m_depth < 8) begin
          m_stack[m_depth[2:0]] = inc;
          m_depth = m_depth + 4'd1;
          m_pc = tgt_i;
        end else begin
          m_pc = inc; m_err = 1'b1;
        end
      end else if (jump_i) begin
        case (jm_i)
          2'b00: taken = 1'b1;
          2'b01: taken = z_i;
          2'b10: taken = c_i;
          default: taken = ~z_i;
        endcase
        m_pc = taken ? tgt_i : inc;
      end else begin
        m_pc = inc;
      end
    end
    exp_q.push_back({m_err, m_depth == 4'd8, m_depth == 4'd0, m_depth, m_pc});
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset asserted between edges; released at a falling edge.
  task automatic test_reset(input string tag);
    logic [W-1:0] got;
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    m_pc = 8'h00; m_depth = 4'd0; m_err = 1'b0;
    exp_q.delete();
    got = observed();
    checks++;
    if (got !== {1'b0, 1'b0, 1'b1, 4'd0, 8'h00}) begin
      failures++;
      $display("FAIL %s_async got=%h exp=%h", tag, got, {1'b0, 1'b0, 1'b1, 4'd0, 8'h00});
    end
    // inputs ignored while held in reset
    PCw = 1'b1; call = 1'b1; ret = 1'b0; jump = 1'b1; j_mode = 2'b00; target = 8'hAA;
    @(posedge clk);
    #1;
    got = observed();
    checks++;
    if (got !== {1'b0, 1'b0, 1'b1, 4'd0, 8'h00}) begin
      failures++;
      $display("FAIL %s_held got=%h exp=%h", tag, got, {1'b0, 1'b0, 1'b1, 4'd0, 8'h00});
    end
    @(negedge clk);
    PCw = 1'b0; call = 1'b0; jump = 1'b0;
    rst = 1'b1;
  endtask

  // Plain increment then hold with PCw low.
  task automatic test_increment();
    logic [W-1:0] got, exp;
    for (int i = 0; i < 5; i++) begin
      step(i < 3, 0, 0, 0, 2'b00, 8'h00, 0, 0);
      got = observed();
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp || pc !== ((i < 3) ? 8'(i + 1) : 8'h03)) begin
        failures++;
        $display("FAIL increment[%0d] got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  // pc=0x10, call 0x40, return to 0x11.
  task automatic test_call_return();
    logic [W-1:0] got, exp;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: step(1, 0, 0, 1, 2'b00, 8'h10, 0, 0);
        1: step(1, 1, 0, 0, 2'b00, 8'h40, 0, 0);
        default: step(1, 0, 1, 0, 2'b00, 8'h00, 0, 0);
      endcase
      got = observed();
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL call_return[%0d] got=%h exp=%h", i, got, exp);
      end
    end
    checks++;
    if (pc !== 8'h11 || stack_depth !== 4'd0 || stack_err !== 1'b0) begin
      failures++;
      $display("FAIL call_return_final pc=%h depth=%0d err=%b exp pc=11 depth=0 err=0",
               pc, stack_depth, stack_err);
    end
  endtask

  // Conditional jumps, including jump ignored under a call.
  task automatic test_jump();
    logic [W-1:0] got, exp;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: step(1, 0, 0, 1, 2'b01, 8'h80, 0, 1);
        1: step(1, 0, 0, 1, 2'b01, 8'h80, 1, 0);
        2: step(1, 0, 0, 1, 2'b11, 8'h30, 1, 0);
        3: step(1, 0, 0, 1, 2'b10, 8'h50, 0, 1);
        4: step(1, 0, 0, 1, 2'b10, 8'h60, 1, 0);
        5: step(1, 1, 0, 1, 2'b00, 8'h70, 0, 0);
        default: step(1, 0, 0, 0, 2'b00, 8'h99, 1, 1);
      endcase
      got = observed();
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL jump[%0d] got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  // Nine calls (overflow), eight LIFO returns, ninth return underflows.
  task automatic test_stack_limits();
    logic [W-1:0] got, exp;
    for (int i = 0; i < 18; i++) begin
      if (i < 9) step(1, 1, 0, 0, 2'b00, 8'($urandom_range(0, 255)), 0, 0);
      else       step(1, 0, 1, 0, 2'b00, 8'h00, 0, 0);
      got = observed();
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL stack_limits[%0d] got=%h exp=%h", i, got, exp);
      end
      if (i == 8) begin
        checks++;
        if (stack_depth !== 4'd8 || stack_full !== 1'b1 || stack_err !== 1'b1) begin
          failures++;
          $display("FAIL overflow depth=%0d full=%b err=%b exp 8 1 1", stack_depth, stack_full, stack_err);
        end
      end
    end
    checks++;
    if (stack_empty !== 1'b1 || stack_depth !== 4'd0) begin
      failures++;
      $display("FAIL underflow empty=%b depth=%0d exp 1 0", stack_empty, stack_depth);
    end
  endtask

  // Wrap at 0xFF, including the pushed return address.
  task automatic test_wrap();
    logic [W-1:0] got, exp;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: step(1, 0, 0, 1, 2'b00, 8'hFF, 0, 0);
        1: step(1, 0, 0, 0, 2'b00, 8'h00, 0, 0);
        2: step(1, 0, 0, 1, 2'b00, 8'hFF, 0, 0);
        3: step(1, 1, 0, 0, 2'b00, 8'h20, 0, 0);
        default: step(1, 0, 1, 0, 2'b00, 8'h00, 0, 0);
      endcase
      got = observed();
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp || ((i == 1 || i == 4) && pc !== 8'h00)) begin
        failures++;
        $display("FAIL wrap[%0d] got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  // Call/return conflict, then reset between a call and its return.
  task automatic test_conflict_reset();
    logic [W-1:0] got, exp;
    step(1, 1, 0, 0, 2'b00, 8'h44, 0, 0);
    exp = exp_q.pop_front();
    step(1, 1, 1, 0, 2'b00, 8'h55, 0, 0);
    got = observed();
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp || pc !== 8'h45 || stack_depth !== 4'd1 || stack_err !== 1'b1) begin
      failures++;
      $display("FAIL conflict got=%h exp=%h", got, exp);
    end
    test_reset("midseq_reset");
    step(1, 0, 1, 0, 2'b00, 8'h00, 0, 0);
    got = observed();
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp || pc !== 8'h01 || stack_err !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_underflow got=%h exp=%h", got, exp);
    end
  endtask

  // Random mix against the model.
  task automatic test_random();
    logic [W-1:0] got, exp;
    for (int i = 0; i < 60; i++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      got = observed();
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL random[%0d] got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; PCw = 1'b0; jump = 1'b0; j_mode = 2'b00; call = 1'b0; ret = 1'b0;
    target = 8'h00; zero = 1'b0; carry = 1'b0;
    m_pc = 8'h00; m_depth = 4'd0; m_err = 1'b0;
    test_reset("reset");
    test_increment();
    test_call_return();
    test_jump();
    test_reset("reset2");
    test_stack_limits();
    test_reset("reset3");
    test_wrap();
    test_reset("reset4");
    test_conflict_reset();
    test_reset("reset5");
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
